// File: rtl/frame_buf_ctrl.sv
// Triple-buffer DDR frame slot manager between capture and host readout.
// Optional FRAME_BUF_TIMESTAMP_EN adds per-slot capture-done timestamps.
module frame_buf_ctrl #(
    parameter int          IMAGE_COLUMNS   = 2592,
    parameter int          IMAGE_ROWS      = 1944,
    parameter int          BYTES_PER_PIXEL = 2,
    parameter logic [29:0] BASE_ADDR       = 30'h0,
    parameter logic [29:0] BUF_STRIDE      = 30'hA00000
) (
    input  logic        clk,
    input  logic        reset_clk,
    input  logic        cap_frame_start,
    input  logic        cap_frame_done,
    output logic        cap_grant,
    output logic [29:0] cap_addr,
    input  logic        readout_req,
    output logic        readout_start,
    output logic [29:0] readout_addr,
    output logic [23:0] readout_count,
    input  logic        readout_done,
    output logic        frame_ready,
    output logic [7:0]  frames_dropped,
    output logic [31:0] readout_timestamp
);

    localparam logic [63:0] FRAME_BYTES64 =
        64'(IMAGE_COLUMNS) * 64'(IMAGE_ROWS) * 64'(BYTES_PER_PIXEL);
    localparam logic [23:0] FRAME_BYTES = FRAME_BYTES64[23:0];

    if (FRAME_BYTES64 > 64'h0000_0000_00FF_FFFF) begin : g_size_err
        $error("frame_buf_ctrl: frame size does not fit readout_count");
    end

    localparam logic [1:0] SL_FREE    = 2'd0;
    localparam logic [1:0] SL_WRITING = 2'd1;
    localparam logic [1:0] SL_READY   = 2'd2;
    localparam logic [1:0] SL_READING = 2'd3;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_WAIT   = 2'd1,
        RD_ACTIVE = 2'd2
    } rd_state_e;

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;

    logic [2:0][1:0]   r_slot;
    logic [2:0][1:0]   w_slot_nxt;
    logic              r_pend;
    logic              w_pend;
    logic              w_pend_nxt;

    logic              w_has_wr;
    logic [1:0]        w_wr_idx;
    logic              w_has_rdy;
    logic [1:0]        w_rdy_idx;
    logic [1:0]        w_alloc_idx;
    logic              w_drop;
    logic              w_ready_nxt;
    logic              w_pick;
    logic              w_release;

    logic              r_cap_grant;
    logic [29:0]       r_cap_addr;
    logic              r_rd_start;
    logic [29:0]       r_rd_addr;
    logic [23:0]       r_rd_count;
    logic              r_frame_ready;
    logic [7:0]        r_dropped;

    function automatic logic [29:0] f_slot_addr(input logic [1:0] idx);
        return BASE_ADDR + ({28'd0, idx} * BUF_STRIDE);
    endfunction

    assign w_pend = r_pend | readout_req;

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (reset_clk) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RD_IDLE: begin
                if (w_pend) w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (w_has_rdy) w_state_nxt = RD_ACTIVE;
            end
            RD_ACTIVE: begin
                if (readout_done) w_state_nxt = w_pend ? RD_WAIT : RD_IDLE;
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        w_pick    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            RD_WAIT:   w_pick    = w_has_rdy;
            RD_ACTIVE: w_release = readout_done;
            default: ;
        endcase
    end

    assign w_pend_nxt = w_pick ? 1'b0 : w_pend;

    always_comb begin
        w_has_wr  = 1'b0;
        w_wr_idx  = 2'd0;
        w_has_rdy = 1'b0;
        w_rdy_idx = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (r_slot[i] == SL_WRITING) begin
                w_has_wr = 1'b1;
                w_wr_idx = 2'(i);
            end
            if (r_slot[i] == SL_READY) begin
                w_has_rdy = 1'b1;
                w_rdy_idx = 2'(i);
            end
        end
    end

    // Order: release, pick, done, then start allocates from what is left free.
    always_comb begin
        w_slot_nxt  = r_slot;
        w_drop      = 1'b0;
        w_alloc_idx = 2'd0;
        w_ready_nxt = 1'b0;
        if (w_release) begin
            for (int i = 0; i < 3; i++) begin
                if (r_slot[i] == SL_READING) w_slot_nxt[i] = SL_FREE;
            end
        end
        if (w_pick) w_slot_nxt[w_rdy_idx] = SL_READING;
        if (cap_frame_done && w_has_wr) begin
            if (w_has_rdy && !w_pick) begin
                w_slot_nxt[w_rdy_idx] = SL_FREE;
                w_drop = 1'b1;
            end
            w_slot_nxt[w_wr_idx] = SL_READY;
        end
        if (cap_frame_start) begin
            if (w_has_wr && !cap_frame_done) begin
                w_slot_nxt[w_wr_idx] = SL_FREE;
                w_drop = 1'b1;
            end
            for (int i = 2; i >= 0; i--) begin
                if (w_slot_nxt[i] == SL_FREE) w_alloc_idx = 2'(i);
            end
            w_slot_nxt[w_alloc_idx] = SL_WRITING;
        end
        for (int i = 0; i < 3; i++) begin
            if (w_slot_nxt[i] == SL_READY) w_ready_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            r_slot        <= {3{SL_FREE}};
            r_pend        <= 1'b0;
            r_cap_grant   <= 1'b0;
            r_cap_addr    <= BASE_ADDR;
            r_rd_start    <= 1'b0;
            r_rd_addr     <= BASE_ADDR;
            r_rd_count    <= 24'd0;
            r_frame_ready <= 1'b0;
            r_dropped     <= 8'd0;
        end else begin
            r_slot        <= w_slot_nxt;
            r_pend        <= w_pend_nxt;
            r_cap_grant   <= cap_frame_start;
            r_rd_start    <= w_pick;
            r_frame_ready <= w_ready_nxt;
            if (cap_frame_start) r_cap_addr <= f_slot_addr(w_alloc_idx);
            if (w_pick) begin
                r_rd_addr  <= f_slot_addr(w_rdy_idx);
                r_rd_count <= FRAME_BYTES;
            end
            if (w_drop && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
        end
    end

`ifdef FRAME_BUF_TIMESTAMP_EN
    logic [31:0]      r_cyc;
    logic [2:0][31:0] r_ts;
    logic [31:0]      r_rd_ts;

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            r_cyc   <= 32'd0;
            r_ts    <= '0;
            r_rd_ts <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (cap_frame_done && w_has_wr) r_ts[w_wr_idx] <= r_cyc;
            if (w_pick) r_rd_ts <= r_ts[w_rdy_idx];
        end
    end

    assign readout_timestamp = r_rd_ts;
`else
    assign readout_timestamp = 32'd0;
`endif

    assign cap_grant      = r_cap_grant;
    assign cap_addr       = r_cap_addr;
    assign readout_start  = r_rd_start;
    assign readout_addr   = r_rd_addr;
    assign readout_count  = r_rd_count;
    assign frame_ready    = r_frame_ready;
    assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed scoreboard bench for frame_buf_ctrl.
// Grants and readout commands are queued with the cycle they are due.
module tb_frame_buf_ctrl;

    localparam logic [29:0] A0 = 30'h0;
    localparam logic [29:0] A1 = 30'h0A00000;
    localparam logic [29:0] A2 = 30'h1400000;
    localparam logic [23:0] FB = 24'd10077696;

    logic        clk;
    logic        reset_clk;
    logic        cap_frame_start;
    logic        cap_frame_done;
    logic        cap_grant;
    logic [29:0] cap_addr;
    logic        readout_req;
    logic        readout_start;
    logic [29:0] readout_addr;
    logic [23:0] readout_count;
    logic        readout_done;
    logic        frame_ready;
    logic [7:0]  frames_dropped;
    logic [31:0] readout_timestamp;

    frame_buf_ctrl dut (
        .clk               (clk),
        .reset_clk         (reset_clk),
        .cap_frame_start   (cap_frame_start),
        .cap_frame_done    (cap_frame_done),
        .cap_grant         (cap_grant),
        .cap_addr          (cap_addr),
        .readout_req       (readout_req),
        .readout_start     (readout_start),
        .readout_addr      (readout_addr),
        .readout_count     (readout_count),
        .readout_done      (readout_done),
        .frame_ready       (frame_ready),
        .frames_dropped    (frames_dropped),
        .readout_timestamp (readout_timestamp)
    );

    typedef struct {
        int          cyc;
        logic [29:0] addr;
    } g_t;

    typedef struct {
        int          cyc;
        logic [29:0] addr;
        logic [23:0] cnt;
        logic [31:0] ts;
    } rd_t;

    g_t  gq[$];
    rd_t rq[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    logic [31:0] tb_cnt;
    logic [31:0] t0, t1, t2, t3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter for expected timestamps
    always @(posedge clk) begin
        if (reset_clk) tb_cnt <= 32'd0;
        else tb_cnt <= tb_cnt + 32'd1;
    end

    function automatic logic [31:0] exp_ts(input logic [31:0] t);
`ifdef FRAME_BUF_TIMESTAMP_EN
        return t;
`else
        return 32'd0 & t;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        g_t  g;
        rd_t r;
        @(posedge clk);
        cyc_n++;
        #1;
        cap_frame_start = 1'b0;
        cap_frame_done  = 1'b0;
        readout_req     = 1'b0;
        readout_done    = 1'b0;
        if (cap_grant) begin
            if (gq.size() == 0) chk("grant_unexp", cap_grant, 0);
            else begin
                g = gq.pop_front();
                chk("grant_cyc", cyc_n, g.cyc);
                chk("grant_addr", cap_addr, g.addr);
            end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc_n) begin
            void'(gq.pop_front());
            chk("grant_miss", cap_grant, 1);
        end
        if (readout_start) begin
            if (rq.size() == 0) chk("rd_unexp", readout_start, 0);
            else begin
                r = rq.pop_front();
                chk("rd_cyc", cyc_n, r.cyc);
                chk("rd_addr", readout_addr, r.addr);
                chk("rd_count", readout_count, r.cnt);
                chk("rd_ts", readout_timestamp, r.ts);
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc_n) begin
            void'(rq.pop_front());
            chk("rd_miss", readout_start, 1);
        end
    endtask

    task automatic do_start(input logic [29:0] a);
        gq.push_back('{cyc_n + 1, a});
        cap_frame_start = 1'b1;
        cyc();
    endtask

    task automatic do_done(output logic [31:0] t);
        cap_frame_done = 1'b1;
        t = tb_cnt;
        cyc();
    endtask

    task automatic push_rd(input int dc, input logic [29:0] a,
                           input logic [31:0] t);
        rq.push_back('{cyc_n + dc, a, FB, exp_ts(t)});
    endtask

    task automatic do_req(input logic [29:0] a, input logic [31:0] t);
        push_rd(2, a, t);
        readout_req = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic do_rdone();
        readout_done = 1'b1;
        cyc();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cap_addr"}, cap_addr, A0);
        chk({tag, "_rd_addr"}, readout_addr, A0);
        chk({tag, "_rd_count"}, readout_count, 0);
        chk({tag, "_frame_ready"}, frame_ready, 0);
        chk({tag, "_dropped"}, frames_dropped, 0);
        chk({tag, "_ts"}, readout_timestamp, 0);
        chk({tag, "_grant"}, cap_grant, 0);
        chk({tag, "_rd_start"}, readout_start, 0);
    endtask

    initial begin
        reset_clk       = 1'b1;
        cap_frame_start = 1'b0;
        cap_frame_done  = 1'b0;
        readout_req     = 1'b0;
        readout_done    = 1'b0;
        repeat (3) cyc();
        reset_clk = 1'b0;
        cyc();
        cyc();
        chk_reset_vals("rst");

        // Single frame: start, done, req
        do_start(A0);
        do_done(t0);
        chk("a_ready", frame_ready, 1);
        do_req(A0, t0);
        chk("a_ready_rd", frame_ready, 0);
        do_rdone();
        cyc();

        // Three frames with no reader: two superseded
        do_start(A0);
        do_done(t0);
        do_start(A1);
        do_done(t0);
        do_start(A0);
        do_done(t2);
        chk("b_dropped", frames_dropped, 2);
        do_req(A0, t2);
        do_rdone();
        cyc();

        // Req while reading, new frame, then release
        do_start(A0);
        do_done(t0);
        do_req(A0, t0);
        readout_req = 1'b1;
        cyc();
        do_start(A1);
        do_done(t1);
        push_rd(2, A1, t1);
        do_rdone();
        cyc();
        do_start(A0);
        do_rdone();
        chk("c_ready", frame_ready, 0);

        // Restart without done, stray readout_done in idle
        do_start(A0);
        chk("d_dropped", frames_dropped, 3);
        do_rdone();
        chk("d_ready0", frame_ready, 0);
        do_done(t2);
        chk("d_ready1", frame_ready, 1);
        do_req(A0, t2);

        // Done with no writing slot is ignored
        cap_frame_done = 1'b1;
        cyc();
        chk("e_dropped", frames_dropped, 3);
        chk("e_ready", frame_ready, 0);

        // Start and done together: done first, then allocate
        do_start(A1);
        gq.push_back('{cyc_n + 1, A2});
        cap_frame_start = 1'b1;
        cap_frame_done  = 1'b1;
        t3 = tb_cnt;
        cyc();
        chk("f_dropped", frames_dropped, 3);
        chk("f_ready", frame_ready, 1);
        do_rdone();
        do_req(A1, t3);
        do_rdone();

        // Done in the pick cycle: pick takes the older ready frame
        do_done(t0);
        do_start(A0);
        readout_req = 1'b1;
        cyc();
        push_rd(1, A2, t0);
        do_done(t1);
        chk("g_dropped", frames_dropped, 3);
        chk("g_ready", frame_ready, 1);
        do_rdone();
        do_req(A0, t1);
        do_rdone();
        cyc();

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) do_start(A0);
        chk("h_sat", frames_dropped, 8'hFF);

        // Reset in the middle of a readout
        do_done(t0);
        do_req(A0, t0);
        reset_clk = 1'b1;
        cyc();
        reset_clk = 1'b0;
        cyc();
        chk_reset_vals("mid");
        do_rdone();
        chk("mid_ready", frame_ready, 0);
        do_start(A0);
        cyc();

        chk("gq_empty", gq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
